// File: rtl/mips_bus_ram_if.sv
// Avalon-style memory port between the MIPS CPU (master) and a bus RAM (slave).
interface mips_bus_ram_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        bus_error;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, bus_error
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, bus_error
    );
endinterface

// File: rtl/mips_bus_ram.sv
// Word-organised RAM slave with programmable wait states, byte-lane writes and a sticky error flag.
// Optional feature: define MIPS_BUS_RAM_RANDOM_WAIT_EN to add LFSR-driven extra wait states per access.
module mips_bus_ram #(
    parameter int          DEPTH_LOG2  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          reset,
    mips_bus_ram_if.slave bus
);

    localparam int WORDS = 1 << DEPTH_LOG2;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  count;
    logic [3:0]  count_next;
    logic [3:0]  wait_len;
    logic        req;
    logic        wait_req;
    logic        accept;
    logic        drop;
    logic        hit;
    logic        do_write;
    logic        do_read;
    logic        proto_err;
    logic [31:0] read_word;
    logic [31:0] mem [WORDS];
    logic [DEPTH_LOG2-1:0] word_idx;

    assign req      = bus.read | bus.write;
    assign word_idx = bus.address[DEPTH_LOG2+1:2];
    // A misaligned address is treated exactly like a decode miss.
    assign hit      = (bus.address[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]) &&
                      (bus.address[1:0] == 2'b00);

`ifdef MIPS_BUS_RAM_RANDOM_WAIT_EN
    logic [7:0] lfsr;

    assign wait_len = 4'(WAIT_CYCLES) + {2'b00, lfsr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 8'hA5;
        end else if (accept) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end
`else
    assign wait_len = 4'(WAIT_CYCLES);
`endif

    always_comb begin
        state_next = state;
        count_next = count;
        wait_req   = 1'b0;
        accept     = 1'b0;
        drop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (wait_len == 4'd0) begin
                        accept = 1'b1;
                    end else begin
                        wait_req   = 1'b1;
                        count_next = wait_len - 4'd1;
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    drop       = 1'b1;
                    state_next = ST_IDLE;
                end else if (count != 4'd0) begin
                    wait_req   = 1'b1;
                    count_next = count - 4'd1;
                end else begin
                    accept     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.waitrequest = wait_req;

    // A write wins over a simultaneous read; reset in the accept cycle cancels the write.
    assign do_write  = accept && bus.write && hit && !reset;
    assign do_read   = accept && bus.read && !bus.write;
    assign proto_err = (accept && (!hit || (bus.read && bus.write))) || drop;
    assign read_word = hit ? mem[word_idx] : 32'h0;

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.byteenable[i]) begin
                    mem[word_idx][8*i +: 8] <= bus.writedata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            count         <= 4'd0;
            bus.readdata  <= 32'h0;
            bus.bus_error <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (do_read) begin
                bus.readdata <= read_word;
            end
            if (proto_err) begin
                bus.bus_error <= 1'b1;
            end
        end
    end

endmodule
